// File: rtl/gerador_jogada_pkg.sv
// Shared definitions for the player-input front end: button bit positions,
// FSM state codes and the opposite-direction cancellation helper.
package gerador_jogada_pkg;

  localparam int unsigned JOG_UP      = 0;
  localparam int unsigned JOG_DOWN    = 1;
  localparam int unsigned JOG_LEFT    = 2;
  localparam int unsigned JOG_RIGHT   = 3;
  localparam int unsigned JOG_SPECIAL = 4;
  localparam int unsigned JOG_SHOT    = 5;
  localparam int unsigned JOG_LARGURA = 6;

  // Bits subject to the shot/special cooldown
  localparam logic [JOG_LARGURA-1:0] MASCARA_ACAO = 6'b110000;

  typedef enum logic [1:0] {
    OCIOSO      = 2'b00,
    AGUARDA_ACK = 2'b01
  } estado_t;

  // Contradictory directions in the same word cancel each other out
  function automatic logic [JOG_LARGURA-1:0] cancela_pares(input logic [JOG_LARGURA-1:0] p);
    logic [JOG_LARGURA-1:0] r;
    r = p;
    if (p[JOG_UP] && p[JOG_DOWN]) begin
      r[JOG_UP]   = 1'b0;
      r[JOG_DOWN] = 1'b0;
    end
    if (p[JOG_LEFT] && p[JOG_RIGHT]) begin
      r[JOG_LEFT]  = 1'b0;
      r[JOG_RIGHT] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/gerador_jogada_if.sv
// Valid/accept handshake carrying the published move word to the game control unit.
interface gerador_jogada_if;
  import gerador_jogada_pkg::*;

  logic [JOG_LARGURA-1:0] jogada;
  logic                   jogada_valida;
  logic                   jogada_aceita;

  modport master (output jogada, output jogada_valida, input  jogada_aceita);
  modport slave  (input  jogada, input  jogada_valida, output jogada_aceita);
endinterface

// File: rtl/gerador_jogada_debouncer.sv
// Per-button conditioner: two-flop synchroniser, counter-based debounce and a
// one-cycle pulse on each debounced 0->1 transition.
module debouncer_botao #(
  parameter int unsigned DEBOUNCE_CICLOS = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic estavel,
  output logic pulso_subida
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CICLOS);

  logic [1:0]    sinc;
  logic [CW-1:0] contador;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc         <= '0;
      estavel      <= 1'b0;
      contador     <= '0;
      pulso_subida <= 1'b0;
    end else begin
      sinc         <= {sinc[0], entrada};
      pulso_subida <= 1'b0;
      if (sinc[1] != estavel) begin
        // The edge that finds the counter at its limit is the last of the run
        if (contador == CW'(DEBOUNCE_CICLOS - 1)) begin
          estavel      <= sinc[1];
          contador     <= '0;
          pulso_subida <= sinc[1];
        end else begin
          contador <= contador + CW'(1);
        end
      end else begin
        contador <= '0;
      end
    end
  end

endmodule

// File: rtl/gerador_jogada.sv
// Player-input front end: debounced button edges accumulate in a pending word that
// is published through a valid/accept handshake, with a shot/special cooldown.
module gerador_jogada
  import gerador_jogada_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = 1000,
  parameter int unsigned RECARGA_TIRO    = 5000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   habilita,
  input  logic [JOG_LARGURA-1:0] botoes,
  gerador_jogada_if.master       jog,
  output logic [1:0]             db_estado,
  output logic                   db_recarga
);

  localparam int unsigned RW = $clog2(RECARGA_TIRO + 1);

  estado_t                estado, estado_prox;
  logic [JOG_LARGURA-1:0] estaveis, pulsos, novos, publicavel;
  logic [JOG_LARGURA-1:0] pendente, pendente_prox;
  logic [JOG_LARGURA-1:0] jogada_q, jogada_prox;
  logic [RW-1:0]          recarga, recarga_prox;

  for (genvar i = 0; i < JOG_LARGURA; i++) begin : g_botao
    debouncer_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_debouncer (
      .clock        (clock),
      .reset        (reset),
      .entrada      (botoes[i]),
      .estavel      (estaveis[i]),
      .pulso_subida (pulsos[i])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= OCIOSO;
      jogada_q <= '0;
      pendente <= '0;
      recarga  <= '0;
    end else begin
      estado   <= estado_prox;
      jogada_q <= jogada_prox;
      pendente <= pendente_prox;
      recarga  <= recarga_prox;
    end
  end

  always_comb begin
    novos         = pulsos & estaveis & ((recarga != '0) ? ~MASCARA_ACAO : '1);
    publicavel    = cancela_pares(pendente);
    estado_prox   = estado;
    jogada_prox   = jogada_q;
    pendente_prox = pendente | novos;
    recarga_prox  = (recarga != '0) ? recarga - RW'(1) : '0;

    if (!habilita) begin
      estado_prox   = OCIOSO;
      jogada_prox   = '0;
      pendente_prox = '0;
      recarga_prox  = '0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (pendente != '0) begin
            // Whole pending word is consumed even when cancellation empties it
            pendente_prox = novos;
            if (publicavel != '0) begin
              jogada_prox = publicavel;
              estado_prox = AGUARDA_ACK;
            end
          end
        end
        AGUARDA_ACK: begin
          if (jog.jogada_aceita) begin
            jogada_prox = '0;
            estado_prox = OCIOSO;
            if ((jogada_q & MASCARA_ACAO) != '0)
              recarga_prox = RW'(RECARGA_TIRO);
          end
        end
        default: estado_prox = OCIOSO;
      endcase
    end
  end

  assign jog.jogada        = jogada_q;
  assign jog.jogada_valida = (estado == AGUARDA_ACK);
  assign db_estado         = estado;
  assign db_recarga        = (recarga != '0);

endmodule

// File: tb/tb_gerador_jogada.sv
// Directed scenarios plus randomized button/handshake traffic, checked every cycle
// against a window-based behavioural model of the input front end.
module tb_gerador_jogada;

  localparam int unsigned D = 4;
  localparam int unsigned R = 10;

  logic       clock;
  logic       reset;
  logic       habilita;
  logic [5:0] botoes;
  logic [1:0] db_estado;
  logic       db_recarga;

  gerador_jogada_if jog();

  gerador_jogada #(.DEBOUNCE_CICLOS(D), .RECARGA_TIRO(R)) dut (
    .clock      (clock),
    .reset      (reset),
    .habilita   (habilita),
    .botoes     (botoes),
    .jog        (jog),
    .db_estado  (db_estado),
    .db_recarga (db_recarga)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned vetores = 0;
  int unsigned erros   = 0;

  // Reference model state
  logic [5:0] hist_raw[$];
  logic [5:0] janela[$];
  logic [5:0] m_est, m_subida, m_pend, m_word;
  bit         m_busy;
  int unsigned m_cool;

  task automatic modelo_reset();
    hist_raw = {6'b0, 6'b0};
    janela   = {};
    m_est = '0; m_subida = '0; m_pend = '0; m_word = '0;
    m_busy = 1'b0; m_cool = 0;
  endtask

  task automatic modelo_borda();
    logic [5:0] sinc, subida_agora, novos, w;
    int unsigned nc;
    bit todos;
    if (!reset) begin
      modelo_reset();
      return;
    end
    // Button press path: the raw value seen two edges ago is the synced sample
    sinc = hist_raw[0];
    hist_raw.push_back(botoes);
    void'(hist_raw.pop_front());
    janela.push_back(sinc);
    if (janela.size() > D) void'(janela.pop_front());
    subida_agora = '0;
    if (janela.size() == D) begin
      for (int i = 0; i < 6; i++) begin
        todos = 1'b1;
        for (int j = 0; j < int'(D); j++)
          if (janela[j][i] == m_est[i]) todos = 1'b0;
        if (todos) begin
          m_est[i] = ~m_est[i];
          subida_agora[i] = m_est[i];
        end
      end
    end
    novos = m_subida;
    if (m_cool != 0) novos[5:4] = 2'b00;
    m_subida = subida_agora;

    if (!habilita) begin
      m_pend = '0; m_cool = 0; m_busy = 1'b0; m_word = '0;
    end else begin
      nc = (m_cool > 0) ? m_cool - 1 : 0;
      if (!m_busy) begin
        if (m_pend != 0) begin
          w = m_pend;
          if (w[0] && w[1]) w[1:0] = 2'b00;
          if (w[2] && w[3]) w[3:2] = 2'b00;
          if (w != 0) begin
            m_word = w;
            m_busy = 1'b1;
          end
          m_pend = novos;
        end else begin
          m_pend = novos;
        end
      end else begin
        m_pend = m_pend | novos;
        if (jog.jogada_aceita) begin
          if (m_word[5:4] != 2'b00) nc = R;
          m_busy = 1'b0;
          m_word = '0;
        end
      end
      m_cool = nc;
    end
  endtask

  task automatic verifica(input string tag);
    vetores++;
    assert (jog.jogada === m_word) else begin
      erros++; $error("FAIL %s jogada obs=%b exp=%b", tag, jog.jogada, m_word);
    end
    vetores++;
    assert (jog.jogada_valida === m_busy) else begin
      erros++; $error("FAIL %s valida obs=%b exp=%b", tag, jog.jogada_valida, m_busy);
    end
    vetores++;
    assert (db_estado === {1'b0, m_busy}) else begin
      erros++; $error("FAIL %s estado obs=%b exp=%b", tag, db_estado, {1'b0, m_busy});
    end
    vetores++;
    assert (db_recarga === (m_cool != 0)) else begin
      erros++; $error("FAIL %s recarga obs=%b exp=%b", tag, db_recarga, (m_cool != 0));
    end
  endtask

  task automatic confere(input string tag, input logic [5:0] obs, input logic [5:0] esp);
    vetores++;
    assert (obs === esp) else begin
      erros++; $error("FAIL %s obs=%b exp=%b", tag, obs, esp);
    end
  endtask

  task automatic ciclo(input string tag);
    @(posedge clock);
    modelo_borda();
    @(negedge clock);
    verifica(tag);
  endtask

  task automatic rodar(input string tag, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) ciclo(tag);
  endtask

  task automatic espera_valida(input string tag, input int unsigned limite);
    int unsigned n;
    n = 0;
    while (!m_busy && n < limite) begin
      ciclo(tag);
      n++;
    end
    vetores++;
    assert (m_busy && jog.jogada_valida === 1'b1) else begin
      erros++; $error("FAIL %s timeout valida obs=%b after %0d cycles", tag, jog.jogada_valida, n);
    end
  endtask

  task automatic aceita(input string tag);
    jog.jogada_aceita = 1'b1;
    ciclo(tag);
    jog.jogada_aceita = 1'b0;
  endtask

  initial begin
    modelo_reset();
    reset = 1'b0; habilita = 1'b1; botoes = '0; jog.jogada_aceita = 1'b0;

    // 1: reset held while buttons toggle, then latency of a held press
    for (int k = 0; k < 6; k++) begin
      botoes = 6'($urandom);
      ciclo("reset_hold");
      confere("reset_valida", {5'b0, jog.jogada_valida}, 6'd0);
      confere("reset_estado", {4'b0, db_estado}, 6'd0);
    end
    reset = 1'b1; botoes = 6'b000001;
    rodar("latencia", 7);
    confere("latencia_c7", {5'b0, jog.jogada_valida}, 6'd0);
    ciclo("latencia");
    confere("latencia_c8_valida", {5'b0, jog.jogada_valida}, 6'd1);
    confere("latencia_c8_jogada", jog.jogada, 6'b000001);
    aceita("aceita1");
    botoes = '0;
    rodar("solta1", 10);

    // 2: glitch shorter than the debounce window
    botoes = 6'b000100;
    rodar("glitch", 3);
    botoes = '0;
    rodar("glitch", 20);
    confere("glitch_valida", {5'b0, jog.jogada_valida}, 6'd0);

    // 3: held handshake, second press accumulates, gap of one idle cycle
    botoes = 6'b000001;
    espera_valida("hs_up", 20);
    botoes = 6'b001001;
    rodar("hs_hold", 20);
    confere("hs_estavel", jog.jogada, 6'b000001);
    aceita("hs_aceita");
    confere("hs_queda", {5'b0, jog.jogada_valida}, 6'd0);
    ciclo("hs_gap");
    confere("hs_prox_valida", {5'b0, jog.jogada_valida}, 6'd1);
    confere("hs_prox_jogada", jog.jogada, 6'b001000);
    aceita("hs_aceita2");
    botoes = '0;
    rodar("hs_solta", 10);

    // 4: cooldown discards shot, not moves
    botoes = 6'b100000;
    espera_valida("cd_tiro", 20);
    confere("cd_tiro_jogada", jog.jogada, 6'b100000);
    botoes = '0;
    rodar("cd_solta", 10);
    aceita("cd_aceita");
    confere("cd_recarga_ativa", {5'b0, db_recarga}, 6'd1);
    botoes = 6'b100000;
    rodar("cd_descarta", 15);
    confere("cd_descartado", {5'b0, jog.jogada_valida}, 6'd0);
    botoes = '0;
    rodar("cd_solta2", 10);
    botoes = 6'b100000;
    espera_valida("cd_tiro2", 20);
    confere("cd_tiro2_jogada", jog.jogada, 6'b100000);
    aceita("cd_aceita2");
    botoes = 6'b000100;
    espera_valida("cd_left", 20);
    confere("cd_left_jogada", jog.jogada, 6'b000100);
    confere("cd_left_recarga", {5'b0, db_recarga}, 6'd1);
    aceita("cd_aceita3");
    botoes = '0;
    rodar("cd_fim", 12);

    // 5: opposite pairs cancel
    botoes = 6'b000011;
    rodar("par_ud", 15);
    confere("par_ud_nada", {5'b0, jog.jogada_valida}, 6'd0);
    botoes = '0;
    rodar("par_solta", 10);
    botoes = 6'b001011;
    espera_valida("par_udr", 20);
    confere("par_udr_jogada", jog.jogada, 6'b001000);
    aceita("par_aceita");
    botoes = '0;
    rodar("par_fim", 10);

    // 6: async reset mid-handshake, then enable drop flushing pending
    botoes = 6'b000001;
    espera_valida("ab_up", 20);
    #3 reset = 1'b0;
    #1;
    modelo_reset();
    confere("ab_reset_valida", {5'b0, jog.jogada_valida}, 6'd0);
    confere("ab_reset_jogada", jog.jogada, 6'd0);
    confere("ab_reset_estado", {4'b0, db_estado}, 6'd0);
    @(negedge clock);
    reset = 1'b1;
    espera_valida("ab_refire", 20);
    botoes = 6'b001001;
    rodar("ab_right", 10);
    habilita = 1'b0;
    ciclo("ab_desab");
    confere("ab_desab_valida", {5'b0, jog.jogada_valida}, 6'd0);
    habilita = 1'b1;
    rodar("ab_reab", 20);
    confere("ab_sem_refire", {5'b0, jog.jogada_valida}, 6'd0);
    botoes = '0;
    rodar("ab_fim", 10);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 6; i++)
        if ($urandom_range(11) == 0) botoes[i] = ~botoes[i];
      jog.jogada_aceita = ($urandom_range(2) == 0);
      habilita = ($urandom_range(199) != 0);
      ciclo("aleatorio");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule
